exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port arst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ex_valid_i 1, ex_opr_a_i 32, ex_opr_b_i 32 (rs2 or immediate), ex_store_data_i 32 (rs2 value), ex_rd_i 5, all inputs.
REQ-005 SHALL have input ex_aluop_i 4 with encoding ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10; other codes yield 0.
REQ-006 SHALL have inputs ex_mdu_en_i 1 and ex_mduop_i 3 with encoding MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7.
REQ-007 SHALL have control inputs ex_rf_en_i 1, ex_dm_en_i 1, ex_wb_sel_i 2, ex_lsuop_i (lsuop_t).
REQ-008 SHALL have inputs flush_i 1 (kill the current instruction) and mem_stall_i 1 (downstream hold).
REQ-009 SHALL have output stall_o 1; upstream holds all ex_* inputs while it is high.
REQ-010 SHALL have registered outputs mem_valid_o 1, mem_rd_o 5, mem_opr_b_o 32 (= store data), mem_opr_res_o 32, mem_rf_en_o, mem_dm_en_o, mem_wb_sel_o 2, mem_lsuop_o, matching the memory-stage input bundle.

Function
REQ-011 SHALL, with ex_mdu_en_i=0, produce the ALU result and latch all fields into the output register at the next rising edge (latency 1).
REQ-012 SHALL use shift amount opr_b[4:0]; SLT/SLTU SHALL return 0 or 1 zero-extended.
REQ-013 SHALL compute MUL/MULH/MULHSU/MULHU in one cycle (low or high 32 bits of the 64-bit product with the RV32M signedness).
REQ-014 SHALL implement DIV/DIVU/REM/REMU with an FSM IDLE -> BUSY -> DONE -> IDLE, using a restoring radix-2 divider with a 5-bit iteration counter.
REQ-015 IDLE with a valid divide op SHALL assert stall_o combinationally, load magnitudes and go BUSY; BUSY SHALL run exactly 32 cycles with stall_o=1, then go DONE.
REQ-016 DONE SHALL deassert stall_o, apply sign correction (quotient negative iff signs differ, remainder takes dividend sign), latch the result and return to IDLE; result is visible at mem_opr_res_o 34 cycles after first presentation.
REQ-017 Divide by zero SHALL go IDLE -> DONE directly: quotient 0xFFFFFFFF, remainder = dividend.
REQ-018 Signed overflow (0x80000000 / -1) SHALL go IDLE -> DONE directly: quotient 0x80000000, remainder 0.
REQ-019 While stall_o=1 and mem_stall_i=0, the output register SHALL load a bubble (mem_valid_o=0, mem_rf_en_o=0, mem_dm_en_o=0).
REQ-020 mem_stall_i=1 SHALL freeze the output register and hold the FSM in DONE; stall_o SHALL be 1 whenever mem_stall_i=1.
REQ-021 flush_i=1 SHALL load a bubble and force the FSM to IDLE in the same edge, aborting any divide; flush_i takes priority over mem_stall_i.
REQ-022 ex_valid_i=0 SHALL load a bubble and not start the FSM.

Reset
REQ-023 arst_n=0 SHALL immediately clear every output register field to 0, the FSM to IDLE, the counter and divider registers to 0; stall_o SHALL be 0 during reset.
REQ-024 Reset asserted mid-divide SHALL abandon it; the first instruction after release SHALL start from IDLE.

Configuration
REQ-025 Macro MDU_DIV_EN: defined -> divider FSM and REQ-014..018 present.
REQ-026 MDU_DIV_EN undefined -> no divider logic; DIV/DIVU/REM/REMU SHALL complete in 1 cycle with result 0 and never raise stall_o.

Verification
REQ-027 ADD 5+(-7), rd=3, rf_en=1 -> next cycle mem_opr_res_o=0xFFFFFFFE, mem_rd_o=3, mem_valid_o=1.
REQ-028 DIV -20/3 (MDU_DIV_EN) -> stall_o high 33 cycles, mem_opr_res_o=0xFFFFFFFA (-6) at cycle 34; REM same operands -> 0xFFFFFFFE.
REQ-029 DIVU 7/0 -> 0xFFFFFFFF two cycles after presentation; REM 0x80000000/0xFFFFFFFF -> 0.
REQ-030 flush_i pulse at BUSY cycle 10 -> FSM IDLE, bubble output, next ADD 1+1 yields 2 after 1 cycle.
REQ-031 mem_stall_i held 3 cycles while result in output register -> outputs unchanged, stall_o=1 throughout.
REQ-032 arst_n low at BUSY cycle 5 -> all outputs 0 immediately; after release MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.

Source files
------------

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// exe_stage : RV32 execute stage. ALU, single-cycle multiplier and an optional
//             restoring divider (enabled by macro MDU_DIV_EN) feeding the
//             memory-stage pipeline register.
// Revision  : 1.0
// ============================================================================
module exe_stage #(
    parameter int XLEN    = 32,
    parameter int LSUOP_W = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               ex_valid_i,
    input  logic [XLEN-1:0]    ex_opr_a_i,
    input  logic [XLEN-1:0]    ex_opr_b_i,
    input  logic [XLEN-1:0]    ex_store_data_i,
    input  logic [4:0]         ex_rd_i,
    input  logic [3:0]         ex_aluop_i,
    input  logic               ex_mdu_en_i,
    input  logic [2:0]         ex_mduop_i,
    input  logic               ex_rf_en_i,
    input  logic               ex_dm_en_i,
    input  logic [1:0]         ex_wb_sel_i,
    input  logic [LSUOP_W-1:0] ex_lsuop_i,
    input  logic               flush_i,
    input  logic               mem_stall_i,
    output logic               stall_o,
    output logic               mem_valid_o,
    output logic [4:0]         mem_rd_o,
    output logic [XLEN-1:0]    mem_opr_b_o,
    output logic [XLEN-1:0]    mem_opr_res_o,
    output logic               mem_rf_en_o,
    output logic               mem_dm_en_o,
    output logic [1:0]         mem_wb_sel_o,
    output logic [LSUOP_W-1:0] mem_lsuop_o
);

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    localparam logic [2:0] c_MDU_MUL    = 3'd0;
    localparam logic [2:0] c_MDU_MULH   = 3'd1;
    localparam logic [2:0] c_MDU_MULHSU = 3'd2;

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic [63:0]     w_mul_a;
    logic [63:0]     w_mul_b;
    logic [63:0]     w_prod;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_div_res;
    logic            w_div_stall;
    logic [XLEN-1:0] w_result;
    logic            w_bubble;

    assign w_shamt = ex_opr_b_i[4:0];

    always_comb begin
        w_alu_res = '0;
        case (ex_aluop_i)
            c_ALU_ADD:   w_alu_res = ex_opr_a_i + ex_opr_b_i;
            c_ALU_SUB:   w_alu_res = ex_opr_a_i - ex_opr_b_i;
            c_ALU_SLL:   w_alu_res = ex_opr_a_i << w_shamt;
            c_ALU_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, $signed(ex_opr_a_i) < $signed(ex_opr_b_i)};
            c_ALU_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, ex_opr_a_i < ex_opr_b_i};
            c_ALU_XOR:   w_alu_res = ex_opr_a_i ^ ex_opr_b_i;
            c_ALU_SRL:   w_alu_res = ex_opr_a_i >> w_shamt;
            c_ALU_SRA:   w_alu_res = $unsigned($signed(ex_opr_a_i) >>> w_shamt);
            c_ALU_OR:    w_alu_res = ex_opr_a_i | ex_opr_b_i;
            c_ALU_AND:   w_alu_res = ex_opr_a_i & ex_opr_b_i;
            c_ALU_PASSB: w_alu_res = ex_opr_b_i;
            default:     w_alu_res = '0;
        endcase
    end

    // Operands are extended to 64 bits per RV32M signedness; the low 64 bits of
    // the unsigned product then equal the true product for every variant.
    assign w_a_sgn   = (ex_mduop_i == c_MDU_MULH) || (ex_mduop_i == c_MDU_MULHSU);
    assign w_b_sgn   = (ex_mduop_i == c_MDU_MULH);
    assign w_mul_a   = {{32{w_a_sgn & ex_opr_a_i[XLEN-1]}}, ex_opr_a_i};
    assign w_mul_b   = {{32{w_b_sgn & ex_opr_b_i[XLEN-1]}}, ex_opr_b_i};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_mul_res = (ex_mduop_i == c_MDU_MUL) ? w_prod[31:0] : w_prod[63:32];

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      r_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;

    logic            w_div_start;
    logic            w_neg_a;
    logic            w_neg_b;
    logic            w_ovf;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;

    assign w_div_start = (r_state == S_IDLE) && ex_valid_i && ex_mdu_en_i && ex_mduop_i[2];
    assign w_div_stall = !flush_i && (w_div_start || (r_state == S_BUSY));

    assign w_neg_a = !ex_mduop_i[0] && ex_opr_a_i[XLEN-1];
    assign w_neg_b = !ex_mduop_i[0] && ex_opr_b_i[XLEN-1];
    assign w_ovf   = !ex_mduop_i[0] && (ex_opr_a_i == c_INT_MIN) && (ex_opr_b_i == '1);
    assign w_mag_a = w_neg_a ? -ex_opr_a_i : ex_opr_a_i;
    assign w_mag_b = w_neg_b ? -ex_opr_b_i : ex_opr_b_i;

    // Partial remainder shifted left by one with the next dividend bit; a clear
    // borrow bit means the divisor fits and the quotient bit is 1.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};

    assign w_div_res = r_is_rem ? (r_neg_r ? -r_rem  : r_rem)
                                : (r_neg_q ? -r_quot : r_quot);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_div_start) begin
                        r_is_rem <= ex_mduop_i[1];
                        r_cnt    <= '0;
                        if (ex_opr_b_i == '0) begin
                            r_quot  <= '1;
                            r_rem   <= ex_opr_a_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_DONE;
                        end else if (w_ovf) begin
                            r_quot  <= c_INT_MIN;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_quot    <= w_mag_a;
                            r_rem     <= '0;
                            r_divisor <= w_mag_b;
                            r_neg_q   <= w_neg_a ^ w_neg_b;
                            r_neg_r   <= w_neg_a;
                            r_state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_trial[XLEN]) begin
                        r_rem  <= w_trial[XLEN-1:0];
                        r_quot <= {r_quot[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_shift[XLEN-1:0];
                        r_quot <= {r_quot[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!mem_stall_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_div_stall = 1'b0;
    assign w_div_res   = '0;
`endif

    always_comb begin
        w_result = w_alu_res;
        if (ex_mdu_en_i) begin
            w_result = ex_mduop_i[2] ? w_div_res : w_mul_res;
        end
    end

    assign stall_o  = arst_n && (mem_stall_i || w_div_stall);
    assign w_bubble = flush_i || (!mem_stall_i && (w_div_stall || !ex_valid_i));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_valid_o   <= 1'b0;
            mem_rd_o      <= '0;
            mem_opr_b_o   <= '0;
            mem_opr_res_o <= '0;
            mem_rf_en_o   <= 1'b0;
            mem_dm_en_o   <= 1'b0;
            mem_wb_sel_o  <= '0;
            mem_lsuop_o   <= '0;
        end else if (w_bubble) begin
            mem_valid_o   <= 1'b0;
            mem_rd_o      <= '0;
            mem_opr_b_o   <= '0;
            mem_opr_res_o <= '0;
            mem_rf_en_o   <= 1'b0;
            mem_dm_en_o   <= 1'b0;
            mem_wb_sel_o  <= '0;
            mem_lsuop_o   <= '0;
        end else if (!mem_stall_i) begin
            mem_valid_o   <= 1'b1;
            mem_rd_o      <= ex_rd_i;
            mem_opr_b_o   <= ex_store_data_i;
            mem_opr_res_o <= w_result;
            mem_rf_en_o   <= ex_rf_en_i;
            mem_dm_en_o   <= ex_dm_en_i;
            mem_wb_sel_o  <= ex_wb_sel_i;
            mem_lsuop_o   <= ex_lsuop_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// tb_exe_stage : randomized self-checking bench for exe_stage against an
//                arithmetic reference model.
// Revision     : 1.0
// ============================================================================
module tb_exe_stage;

`ifdef MDU_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [3:0]  aluop;
        logic        mdu;
        logic [2:0]  mduop;
        logic        rf_en;
        logic        dm_en;
        logic [1:0]  wb_sel;
        logic [3:0]  lsuop;
    } instr_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        ex_valid_i;
    logic [31:0] ex_opr_a_i;
    logic [31:0] ex_opr_b_i;
    logic [31:0] ex_store_data_i;
    logic [4:0]  ex_rd_i;
    logic [3:0]  ex_aluop_i;
    logic        ex_mdu_en_i;
    logic [2:0]  ex_mduop_i;
    logic        ex_rf_en_i;
    logic        ex_dm_en_i;
    logic [1:0]  ex_wb_sel_i;
    logic [3:0]  ex_lsuop_i;
    logic        flush_i;
    logic        mem_stall_i;
    logic        stall_o;
    logic        mem_valid_o;
    logic [4:0]  mem_rd_o;
    logic [31:0] mem_opr_b_o;
    logic [31:0] mem_opr_res_o;
    logic        mem_rf_en_o;
    logic        mem_dm_en_o;
    logic [1:0]  mem_wb_sel_o;
    logic [3:0]  mem_lsuop_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exe_stage #(.XLEN(32), .LSUOP_W(4)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .ex_valid_i      (ex_valid_i),
        .ex_opr_a_i      (ex_opr_a_i),
        .ex_opr_b_i      (ex_opr_b_i),
        .ex_store_data_i (ex_store_data_i),
        .ex_rd_i         (ex_rd_i),
        .ex_aluop_i      (ex_aluop_i),
        .ex_mdu_en_i     (ex_mdu_en_i),
        .ex_mduop_i      (ex_mduop_i),
        .ex_rf_en_i      (ex_rf_en_i),
        .ex_dm_en_i      (ex_dm_en_i),
        .ex_wb_sel_i     (ex_wb_sel_i),
        .ex_lsuop_i      (ex_lsuop_i),
        .flush_i         (flush_i),
        .mem_stall_i     (mem_stall_i),
        .stall_o         (stall_o),
        .mem_valid_o     (mem_valid_o),
        .mem_rd_o        (mem_rd_o),
        .mem_opr_b_o     (mem_opr_b_o),
        .mem_opr_res_o   (mem_opr_res_o),
        .mem_rf_en_o     (mem_rf_en_o),
        .mem_dm_en_o     (mem_dm_en_o),
        .mem_wb_sel_o    (mem_wb_sel_o),
        .mem_lsuop_o     (mem_lsuop_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input instr_t t);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] u;
        sa = t.a;
        sb = t.b;
        if (t.mdu) begin
            case (t.mduop)
                3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
                3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
                3'd2: begin p = longint'(sa) * longint'({32'b0, t.b}); return p[63:32]; end
                3'd3: begin u = {32'b0, t.a} * {32'b0, t.b}; return u[63:32]; end
                default: begin
                    if (!c_DIV_EN) return 32'd0;
                    if (t.mduop == 3'd4) begin
                        if (t.b == 0) return 32'hFFFFFFFF;
                        if (t.a == 32'h80000000 && t.b == 32'hFFFFFFFF) return 32'h80000000;
                        return sa / sb;
                    end
                    if (t.mduop == 3'd5) return (t.b == 0) ? 32'hFFFFFFFF : t.a / t.b;
                    if (t.mduop == 3'd6) begin
                        if (t.b == 0) return t.a;
                        if (t.a == 32'h80000000 && t.b == 32'hFFFFFFFF) return 32'd0;
                        return sa % sb;
                    end
                    return (t.b == 0) ? t.a : t.a % t.b;
                end
            endcase
        end
        case (t.aluop)
            4'd0:    return t.a + t.b;
            4'd1:    return t.a - t.b;
            4'd2:    return t.a << t.b[4:0];
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (t.a < t.b) ? 32'd1 : 32'd0;
            4'd5:    return t.a ^ t.b;
            4'd6:    return t.a >> t.b[4:0];
            4'd7:    return sa >>> t.b[4:0];
            4'd8:    return t.a | t.b;
            4'd9:    return t.a & t.b;
            4'd10:   return t.b;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles during which stall_o is high, counted from presentation.
    function automatic int exp_stall(input instr_t t);
        if (!c_DIV_EN || !t.valid || !t.mdu || !t.mduop[2]) return 0;
        if (t.b == 0) return 1;
        if (!t.mduop[0] && t.a == 32'h80000000 && t.b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic instr_t mk(input logic mdu, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        instr_t t;
        t.valid  = 1'b1;
        t.a      = a;
        t.b      = b;
        t.sd     = b ^ 32'h5A5A0000;
        t.rd     = rd;
        t.aluop  = mdu ? 4'd0 : op;
        t.mdu    = mdu;
        t.mduop  = op[2:0];
        t.rf_en  = 1'b1;
        t.dm_en  = 1'b0;
        t.wb_sel = 2'd1;
        t.lsuop  = 4'd3;
        return t;
    endfunction

    task automatic apply(input instr_t t);
        ex_valid_i      = t.valid;
        ex_opr_a_i      = t.a;
        ex_opr_b_i      = t.b;
        ex_store_data_i = t.sd;
        ex_rd_i         = t.rd;
        ex_aluop_i      = t.aluop;
        ex_mdu_en_i     = t.mdu;
        ex_mduop_i      = t.mduop;
        ex_rf_en_i      = t.rf_en;
        ex_dm_en_i      = t.dm_en;
        ex_wb_sel_i     = t.wb_sel;
        ex_lsuop_i      = t.lsuop;
    endtask

    // Present one instruction, hold it while stalled, then check the register.
    task automatic run(input instr_t t, input string tag);
        int stalls = 0;
        apply(t);
        @(negedge clk);
        while (stall_o === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge clk); #1;
            if (stalls == 1) check({tag, " bubble"}, {31'b0, mem_valid_o}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        check({tag, " stall"}, stalls, exp_stall(t));
        check({tag, " ctl"}, {29'b0, mem_valid_o, mem_rf_en_o, mem_dm_en_o},
              t.valid ? {29'b0, 1'b1, t.rf_en, t.dm_en} : 32'd0);
        if (t.valid) begin
            check({tag, " res"}, mem_opr_res_o, ref_res(t));
            check({tag, " fld"}, {21'b0, mem_rd_o, mem_wb_sel_o, mem_lsuop_o}, {21'b0, t.rd, t.wb_sel, t.lsuop});
            check({tag, " sd"}, mem_opr_b_o, t.sd);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        logic [31:0] held_res;
        logic [4:0]  held_rd;

        arst_n      = 1'b0;
        flush_i     = 1'b0;
        mem_stall_i = 1'b0;
        apply(mk(1'b1, 4'd4, -32'sd20, 32'd3, 5'd1));
        #12;
        check("reset stall", {31'b0, stall_o}, 32'd0);
        check("reset valid", {31'b0, mem_valid_o}, 32'd0);
        check("reset res", mem_opr_res_o, 32'd0);
        check("reset fld", {22'b0, mem_rd_o, mem_rf_en_o, mem_dm_en_o, mem_wb_sel_o}, 32'd0);
        ex_valid_i = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;

        run(mk(1'b0, 4'd0, 32'd5, -32'sd7, 5'd3), "add 5-7");
        run(mk(1'b0, 4'd2, 32'd1, 32'd35, 5'd4), "sll shamt");
        run(mk(1'b0, 4'd7, 32'h80000000, 32'd31, 5'd5), "sra 31");
        run(mk(1'b0, 4'd3, 32'hFFFFFFFF, 32'd1, 5'd6), "slt");
        run(mk(1'b0, 4'd4, 32'hFFFFFFFF, 32'd1, 5'd7), "sltu");
        run(mk(1'b0, 4'd15, 32'h1234, 32'h5678, 5'd8), "bad op");
        run(mk(1'b1, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9), "mulh");
        run(mk(1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10), "mulhsu");

        for (int i = 0; i < 40; i++) begin
            t        = mk($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom));
            t.mduop  = 3'($urandom_range(0, 3));
            t.valid  = ($urandom_range(0, 7) != 0);
            t.sd     = $urandom;
            t.rf_en  = 1'($urandom);
            t.dm_en  = 1'($urandom);
            t.wb_sel = 2'($urandom);
            t.lsuop  = 4'($urandom);
            run(t, "rand alu/mul");
        end

        run(mk(1'b1, 4'd4, -32'sd20, 32'd3, 5'd11), "div -20/3");
        run(mk(1'b1, 4'd6, -32'sd20, 32'd3, 5'd12), "rem -20/3");
        run(mk(1'b1, 4'd5, 32'd7, 32'd0, 5'd13), "divu /0");
        run(mk(1'b1, 4'd7, 32'd7, 32'd0, 5'd14), "remu /0");
        run(mk(1'b1, 4'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15), "rem ovf");
        run(mk(1'b1, 4'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16), "div ovf");
        run(mk(1'b1, 4'd4, 32'd7, -32'sd2, 5'd17), "div 7/-2");
        run(mk(1'b1, 4'd5, 32'hFFFFFFF0, 32'd3, 5'd18), "divu big");
        for (int i = 0; i < 8; i++) begin
            t   = mk(1'b1, 4'($urandom_range(4, 7)), $urandom, 32'($urandom_range(0, 9)), 5'($urandom));
            if (i % 2 == 1) t.b = $urandom;
            run(t, "rand div");
        end

        t       = mk(1'b1, 4'd4, 32'd100, 32'd7, 5'd19);
        t.valid = 1'b0;
        run(t, "invalid div");

        // Flush ten cycles into a divide, then a plain ADD must flow through.
        apply(mk(1'b1, 4'd4, 32'd100, 32'd7, 5'd20));
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush bubble", {31'b0, mem_valid_o}, 32'd0);
        run(mk(1'b0, 4'd0, 32'd1, 32'd1, 5'd21), "add after flush");

        run(mk(1'b0, 4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd22), "xor");
        held_res    = mem_opr_res_o;
        held_rd     = mem_rd_o;
        mem_stall_i = 1'b1;
        apply(mk(1'b0, 4'd8, 32'h00000011, 32'h00000022, 5'd23));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("memstall stall_o", {31'b0, stall_o}, 32'd1);
            @(posedge clk); #1;
            check("memstall hold", {mem_rd_o, mem_opr_res_o[26:0]}, {held_rd, held_res[26:0]});
            check("memstall valid", {31'b0, mem_valid_o}, 32'd1);
        end
        mem_stall_i = 1'b0;
        run(mk(1'b0, 4'd8, 32'h00000011, 32'h00000022, 5'd23), "or after stall");

        // Downstream hold while a divide-by-zero result is pending.
        t = mk(1'b1, 4'd4, 32'd9, 32'd0, 5'd24);
        apply(t);
        @(posedge clk); #1;
        mem_stall_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_stall_i = 1'b0;
        @(negedge clk);
        check("done hold stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        check("done hold res", mem_opr_res_o, ref_res(t));

        // Asynchronous reset with a valid result in the register.
        run(mk(1'b0, 4'd0, 32'd40, 32'd2, 5'd25), "add 40+2");
        #2;
        arst_n = 1'b0;
        #1;
        check("async rst res", mem_opr_res_o, 32'd0);
        check("async rst valid", {31'b0, mem_valid_o}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Reset five cycles into a divide.
        apply(mk(1'b1, 4'd4, -32'sd20, 32'd3, 5'd26));
        repeat (5) @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check("mid-div rst stall", {31'b0, stall_o}, 32'd0);
        check("mid-div rst out", {mem_valid_o, mem_rf_en_o, mem_rd_o, mem_opr_res_o[24:0]}, 32'd0);
        ex_valid_i = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        run(mk(1'b1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd27), "mulhu after rst");
        run(mk(1'b1, 4'd4, -32'sd20, 32'd3, 5'd28), "div after rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
